// File: rtl/chroma_upsampler_if.sv
// Stream bundle for chroma_upsampler: chroma pair beats in, even/odd position pairs out.
interface chroma_upsampler_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_sol;
    logic [NUM_CH*2*DATA_W-1:0]   in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [NUM_CH*DATA_W-1:0]     out_even;
    logic [NUM_CH*DATA_W-1:0]     out_odd;
    logic                         out_eol;
    logic                         sol_err;

    modport slave (
        input  in_valid, in_sol, in_data, out_ready,
        output in_ready, out_valid, out_even, out_odd, out_eol, sol_err
    );

    modport master (
        output in_valid, in_sol, in_data, out_ready,
        input  in_ready, out_valid, out_even, out_odd, out_eol, sol_err
    );
endinterface

// File: rtl/chroma_upsampler.sv
// NUM_CH-channel 6-tap horizontal chroma 2x upsampler with one shared multiplier.
// Define CHROMA_UPSAMPLER_CLIP_EN to saturate the interpolated sample; otherwise it wraps.
module chroma_upsampler #(
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 8,
    parameter int LINE_LEN = 160,
    parameter int C0       = 21,
    parameter int C1       = 52,
    parameter int C2       = 159
) (
    input  logic             CLOCK_50_I,
    input  logic             resetn,
    chroma_upsampler_if.slave bus
);
    localparam int HALF   = LINE_LEN / 2;
    localparam int J_W    = $clog2(LINE_LEN);
    localparam int BEAT_W = $clog2(HALF + 1);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SUM_W  = DATA_W + 1;
    localparam logic signed [31:0] MAX_V = (32'sd1 <<< DATA_W) - 32'sd1;

    typedef enum logic [2:0] {IDLE, LOAD, MAC, OUT, SHIFT} state_t;
    state_t state_reg, state_next;

    logic [J_W-1:0]    j_reg;
    logic [BEAT_W-1:0] beats_reg;
    logic              pair_valid_reg;
    logic [CH_W-1:0]   ch_reg;
    logic [1:0]        tap_reg;
    logic signed [31:0] acc_reg;
    logic              sol_err_reg;

    logic in_ready_c, beat_fire, need_beat, shift_now, mac_last, last_pos;
    logic [NUM_CH-1:0][2:0][SUM_W-1:0] tap_sum;
    logic [SUM_W-1:0]   sum_sel;
    logic signed [31:0] coef_sel, prod, acc_next, acc_shift;
    logic [DATA_W-1:0]  odd_val;

    // A new right-edge sample needs a beat only when the pair buffer is empty and the line is not exhausted.
    always_comb begin
        need_beat = !pair_valid_reg && (beats_reg != BEAT_W'(HALF));
        last_pos  = (j_reg == J_W'(LINE_LEN - 1));
        mac_last  = (ch_reg == CH_W'(NUM_CH - 1)) && (tap_reg == 2'd2);
        case (state_reg)
            IDLE, LOAD: in_ready_c = 1'b1;
            SHIFT:      in_ready_c = need_beat;
            default:    in_ready_c = 1'b0;
        endcase
        beat_fire = bus.in_valid && in_ready_c;
        shift_now = (state_reg == SHIFT) && (!need_beat || bus.in_valid);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (beat_fire && bus.in_sol) state_next = LOAD;
            LOAD:  if (beat_fire) state_next = MAC;
            MAC:   if (mac_last) state_next = OUT;
            OUT:   if (bus.out_ready) state_next = last_pos ? IDLE : SHIFT;
            SHIFT: if (shift_now) state_next = MAC;
            default: state_next = IDLE;
        endcase
    end

    // One multiply per cycle: channel-major, taps C0 (outer), C1 (middle, subtracted), C2 (inner).
    always_comb begin
        sum_sel = tap_sum[ch_reg][tap_reg];
        case (tap_reg)
            2'd0:    coef_sel = C0;
            2'd1:    coef_sel = C1;
            default: coef_sel = C2;
        endcase
        prod      = coef_sel * $signed({{(32-SUM_W){1'b0}}, sum_sel});
        acc_next  = ((tap_reg == 2'd0) ? 32'sd128 : acc_reg) + ((tap_reg == 2'd1) ? -prod : prod);
        acc_shift = acc_next >>> 8;
`ifdef CHROMA_UPSAMPLER_CLIP_EN
        if (acc_shift < 32'sd0)
            odd_val = '0;
        else if (acc_shift > MAX_V)
            odd_val = '1;
        else
            odd_val = acc_shift[DATA_W-1:0];
`else
        odd_val = acc_shift[DATA_W-1:0];
`endif
    end

    always_ff @(posedge CLOCK_50_I) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            j_reg          <= '0;
            beats_reg      <= '0;
            pair_valid_reg <= 1'b0;
            ch_reg         <= '0;
            tap_reg        <= '0;
            acc_reg        <= '0;
            sol_err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == MAC) begin
                acc_reg <= acc_next;
                if (tap_reg == 2'd2) begin
                    tap_reg <= '0;
                    ch_reg  <= ch_reg + 1'b1;
                end else begin
                    tap_reg <= tap_reg + 1'b1;
                end
            end else begin
                tap_reg <= '0;
                ch_reg  <= '0;
            end
            if (state_reg == IDLE && beat_fire && bus.in_sol) begin
                j_reg          <= '0;
                beats_reg      <= BEAT_W'(1);
                pair_valid_reg <= 1'b0;
            end
            if (state_reg == LOAD && beat_fire)
                beats_reg <= BEAT_W'(2);
            if (shift_now) begin
                j_reg <= j_reg + 1'b1;
                if (pair_valid_reg) begin
                    pair_valid_reg <= 1'b0;
                end else if (need_beat) begin
                    pair_valid_reg <= 1'b1;
                    beats_reg      <= beats_reg + 1'b1;
                end
            end
            if (beat_fire && bus.in_sol && (state_reg == LOAD || state_reg == SHIFT))
                sol_err_reg <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DATA_W-1:0] win_reg [6];
        logic [DATA_W-1:0] pair_reg;
        logic [DATA_W-1:0] res_reg;
        logic [DATA_W-1:0] s_hi, s_lo;

        assign s_hi = bus.in_data[gi*2*DATA_W + DATA_W +: DATA_W];
        assign s_lo = bus.in_data[gi*2*DATA_W +: DATA_W];

        always_ff @(posedge CLOCK_50_I) begin
            if (!resetn) begin
                for (int k = 0; k < 6; k++) win_reg[k] <= '0;
                pair_reg <= '0;
                res_reg  <= '0;
            end else begin
                // The window starts left-edge replicated: u0,u0,u0,u1 then u2,u3 from the LOAD beat.
                if (state_reg == IDLE && beat_fire && bus.in_sol) begin
                    win_reg[0] <= s_hi;
                    win_reg[1] <= s_hi;
                    win_reg[2] <= s_hi;
                    win_reg[3] <= s_lo;
                end
                if (state_reg == LOAD && beat_fire) begin
                    win_reg[4] <= s_hi;
                    win_reg[5] <= s_lo;
                end
                if (shift_now) begin
                    for (int k = 0; k < 5; k++) win_reg[k] <= win_reg[k+1];
                    if (pair_valid_reg) begin
                        win_reg[5] <= pair_reg;
                    end else if (need_beat) begin
                        win_reg[5] <= s_hi;
                        pair_reg   <= s_lo;
                    end
                end
                if (state_reg == MAC && tap_reg == 2'd2 && ch_reg == CH_W'(gi))
                    res_reg <= odd_val;
            end
        end

        assign tap_sum[gi][0] = SUM_W'(win_reg[0]) + SUM_W'(win_reg[5]);
        assign tap_sum[gi][1] = SUM_W'(win_reg[1]) + SUM_W'(win_reg[4]);
        assign tap_sum[gi][2] = SUM_W'(win_reg[2]) + SUM_W'(win_reg[3]);

        assign bus.out_even[gi*DATA_W +: DATA_W] = (state_reg == OUT) ? win_reg[2] : '0;
        assign bus.out_odd[gi*DATA_W +: DATA_W]  = (state_reg == OUT) ? res_reg : '0;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_reg == OUT);
    assign bus.out_eol   = (state_reg == OUT) && last_pos;
    assign bus.sol_err   = sol_err_reg;
endmodule

// File: tb/tb_chroma_upsampler.sv
// Directed bench for chroma_upsampler: a line-level reference model feeds a scoreboard
// checked on every output transfer, plus hand-computed literal expectations.
module tb_chroma_upsampler;
    localparam int NUM_CH   = 2;
    localparam int DATA_W   = 8;
    localparam int LINE_LEN = 8;
    localparam int C0 = 21;
    localparam int C1 = 52;
    localparam int C2 = 159;

    logic CLOCK_50_I = 1'b0;
    logic resetn     = 1'b0;

    chroma_upsampler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    chroma_upsampler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .LINE_LEN(LINE_LEN),
        .C0(C0), .C1(C1), .C2(C2)
    ) dut (
        .CLOCK_50_I(CLOCK_50_I),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 CLOCK_50_I = ~CLOCK_50_I;

    typedef struct packed {
        logic [NUM_CH*DATA_W-1:0] even;
        logic [NUM_CH*DATA_W-1:0] odd;
        logic                     eol;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   pos = 0;
    int   beats = 0;
    bit   bp_armed = 0;
    logic [7:0] obs_u_odd [LINE_LEN];
    logic [7:0] line_u [LINE_LEN];
    logic [7:0] line_v [LINE_LEN];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d", name, $signed(act), $signed(req));
        end
    endtask

    function automatic int clampi(input int i);
        if (i < 0) return 0;
        if (i > LINE_LEN - 1) return LINE_LEN - 1;
        return i;
    endfunction

    // Straight from the filter equation with edge-replicated indices.
    function automatic int model_raw(input logic [7:0] a [LINE_LEN], input int j);
        int s_outer, s_mid, s_inner, acc;
        s_outer = int'(a[clampi(j-2)]) + int'(a[clampi(j+3)]);
        s_mid   = int'(a[clampi(j-1)]) + int'(a[clampi(j+2)]);
        s_inner = int'(a[clampi(j)])   + int'(a[clampi(j+1)]);
        acc = C0*s_outer - C1*s_mid + C2*s_inner + 128;
        return acc >>> 8;
    endfunction

    function automatic int model_odd(input logic [7:0] a [LINE_LEN], input int j);
        int r;
        r = model_raw(a, j);
`ifdef CHROMA_UPSAMPLER_CLIP_EN
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
`else
        return r & 255;
`endif
    endfunction

    task automatic push_line();
        exp_t e;
        for (int j = 0; j < LINE_LEN; j++) begin
            e.even = {line_v[j], line_u[j]};
            e.odd  = {8'(model_odd(line_v, j)), 8'(model_odd(line_u, j))};
            e.eol  = (j == LINE_LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_beat(input logic [7:0] u_hi, input logic [7:0] u_lo,
                             input logic [7:0] v_hi, input logic [7:0] v_lo, input logic sol);
        bit got = 0;
        bus.in_valid = 1'b1;
        bus.in_sol   = sol;
        bus.in_data  = {v_hi, v_lo, u_hi, u_lo};
        for (int w = 0; w < 500; w++) begin
            @(negedge CLOCK_50_I);
            if (bus.in_ready) begin
                got = 1;
                break;
            end
        end
        if (got) begin
            @(posedge CLOCK_50_I);
            #1;
            beats++;
        end else begin
            check("in_ready_timeout", bus.in_ready, 1);
        end
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
    endtask

    task automatic send_line(input bit stray_sol);
        push_line();
        for (int k = 0; k < LINE_LEN/2; k++)
            send_beat(line_u[2*k], line_u[2*k+1], line_v[2*k], line_v[2*k+1],
                      (k == 0) || (stray_sol && k == 2));
    endtask

    task automatic wait_drain(input string name);
        for (int w = 0; w < 2000; w++) begin
            @(negedge CLOCK_50_I);
            if (exp_q.size() == 0) break;
        end
        check(name, exp_q.size(), 0);
        @(posedge CLOCK_50_I);
        #1;
    endtask

    task automatic set_line_a();
        for (int i = 0; i < LINE_LEN; i++) begin
            line_u[i] = 8'd100;
            line_v[i] = 8'd37;
        end
    endtask

    task automatic set_line_b();
        for (int i = 0; i < LINE_LEN; i++) begin
            line_u[i] = (i < 4) ? 8'd0 : 8'd255;
            line_v[i] = 8'(10 * (i + 1));
        end
    endtask

    // Scoreboard: a transfer happens at the next rising edge when valid and ready are both high now.
    always @(negedge CLOCK_50_I) begin
        if (!resetn) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_out_even", bus.out_even, 0);
            check("rst_out_odd", bus.out_odd, 0);
            exp_q.delete();
            pos = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out_valid", bus.out_valid, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("even_j%0d", pos), bus.out_even, e.even);
                check($sformatf("odd_j%0d", pos), bus.out_odd, e.odd);
                check($sformatf("eol_j%0d", pos), bus.out_eol, e.eol);
                obs_u_odd[pos] = bus.out_odd[7:0];
                pos = e.eol ? 0 : pos + 1;
            end
        end
    end

    // Back-pressure: hold out_ready low for 10 cycles once position 3 is presented.
    initial begin
        logic [15:0] hold_even, hold_odd;
        int hold_beats;
        forever begin
            @(posedge CLOCK_50_I);
            #1;
            if (bp_armed && bus.out_valid && pos == 3) begin
                bp_armed = 0;
                bus.out_ready = 1'b0;
                hold_even  = bus.out_even;
                hold_odd   = bus.out_odd;
                hold_beats = beats;
                for (int c = 0; c < 10; c++) begin
                    @(negedge CLOCK_50_I);
                    check("bp_even_stable", bus.out_even, hold_even);
                    check("bp_odd_stable", bus.out_odd, hold_odd);
                    check("bp_in_ready", bus.in_ready, 0);
                    check("bp_valid_held", bus.out_valid, 1);
                end
                check("bp_no_beat", beats, hold_beats);
                @(posedge CLOCK_50_I);
                #1;
                bus.out_ready = 1'b1;
            end
        end
    end

    initial begin
        int b0;
        bit hit;
        bus.in_valid  = 1'b0;
        bus.in_sol    = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        resetn        = 1'b0;
        repeat (4) @(posedge CLOCK_50_I);
        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_sol_err", bus.sol_err, 0);
        check("reset_out_eol", bus.out_eol, 0);
        resetn = 1'b1;

        // A beat without in_sol while idle is dropped and produces nothing.
        send_beat(8'hAA, 8'h55, 8'h11, 8'h22, 1'b0);
        repeat (10) @(negedge CLOCK_50_I);
        check("drop_no_output", bus.out_valid, 0);
        check("drop_in_ready", bus.in_ready, 1);
        check("drop_sol_err", bus.sol_err, 0);

        // Line A: constant U=100, V=37.
        set_line_a();
        check("model_a_u_odd", model_odd(line_u, 3), 100);
        check("model_a_v_odd", model_odd(line_v, 7), 37);
        b0 = beats;
        send_line(0);
        wait_drain("drain_a");
        check("a_beats", beats - b0, 4);
        check("a_in_ready_idle", bus.in_ready, 1);
        check("a_u_odd_j7", obs_u_odd[7], 100);
        check("a_u_odd_j0", obs_u_odd[0], 100);

        // Line B: step edge.
        set_line_b();
        check("model_b_raw_j2", model_raw(line_u, 2), -31);
        check("model_b_raw_j4", model_raw(line_u, 4), 286);
        check("model_b_raw_j3", model_raw(line_u, 3), 128);
        send_line(0);
        wait_drain("drain_b");
`ifdef CHROMA_UPSAMPLER_CLIP_EN
        check("b_u_odd_j2", obs_u_odd[2], 0);
        check("b_u_odd_j4", obs_u_odd[4], 255);
`else
        check("b_u_odd_j2", obs_u_odd[2], 225);
        check("b_u_odd_j4", obs_u_odd[4], 30);
`endif
        check("b_u_odd_j3", obs_u_odd[3], 128);
        check("b_u_odd_j7", obs_u_odd[7], 255);

        // Line C: same data, stalled at position 3.
        bp_armed = 1;
        send_line(0);
        wait_drain("drain_c");
        check("bp_reached", bp_armed, 0);
        check("c_u_odd_j3", obs_u_odd[3], 128);

        // Line D: reset during the MAC of position 5, then a fresh line.
        send_line(0);
        hit = 0;
        for (int w = 0; w < 300; w++) begin
            @(posedge CLOCK_50_I);
            #1;
            if (pos == 5) begin
                hit = 1;
                break;
            end
        end
        check("d_reach_j5", pos, 5);
        if (hit) begin
            @(posedge CLOCK_50_I);
            #1;
        end
        resetn = 1'b0;
        repeat (3) @(posedge CLOCK_50_I);
        #1;
        check("d_rst_sol_err", bus.sol_err, 0);
        resetn = 1'b1;
        for (int i = 0; i < LINE_LEN; i++) begin
            line_u[i] = 8'(5 + 30 * i);
            line_v[i] = 8'(200 - 20 * i);
        end
        send_line(0);
        wait_drain("drain_e");
        check("e_sol_err", bus.sol_err, 0);
        check("e_u_even_j0_model", {24'd0, line_u[0]}, 5);

        // Line F: stray in_sol on the third beat.
        set_line_b();
        send_line(1);
        wait_drain("drain_f");
        check("f_sol_err", bus.sol_err, 1);
        check("f_u_odd_j3", obs_u_odd[3], 128);

        // Line G: sol_err stays sticky across a clean line.
        set_line_a();
        send_line(0);
        wait_drain("drain_g");
        check("g_sol_err_sticky", bus.sol_err, 1);
        check("g_u_odd_j5", obs_u_odd[5], 100);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, tests_failed=%0d", tests_failed);
        $fatal(1, "watchdog");
    end
endmodule
